// File: rtl/wb_select_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module      : wb_select_stage_pkg
// Description : Shared definitions for the writeback select stage:
//               load-extension opcodes and the GPR index width.
// Revision    : 1.0  initial release
// ============================================================================
package wb_select_stage_pkg;

  // Load-extension opcodes carried on in_ext_op
  localparam logic [2:0] EXT_NONE = 3'd0;  // no extension (also lw)
  localparam logic [2:0] EXT_LB   = 3'd1;
  localparam logic [2:0] EXT_LBU  = 3'd2;
  localparam logic [2:0] EXT_LH   = 3'd3;
  localparam logic [2:0] EXT_LHU  = 3'd4;

  // Register-file index width
  localparam int GPR_W = 5;

endpackage
`default_nettype wire

// File: rtl/wb_select_stage_load_ext.sv
`default_nettype none
// ============================================================================
// Module      : load_ext
// Description : Combinational MIPS load extension (lb/lbu/lh/lhu/lw) of a
//               32-bit memory word.
// Ports       : i_data     32-bit word read from memory
//               i_ext_op   extension opcode (EXT_* in the package)
//               i_addr_lo  load address bits [1:0]
//               o_data     extended result
//               o_err      misaligned halfword or undefined opcode
// Revision    : 1.0  initial release
// ============================================================================
module load_ext
  import wb_select_stage_pkg::*;
(
  input  logic [31:0] i_data,
  input  logic [2:0]  i_ext_op,
  input  logic [1:0]  i_addr_lo,
  output logic [31:0] o_data,
  output logic        o_err
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    case (i_addr_lo)
      2'd0:    w_byte = i_data[7:0];
      2'd1:    w_byte = i_data[15:8];
      2'd2:    w_byte = i_data[23:16];
      default: w_byte = i_data[31:24];
    endcase
    w_half = i_addr_lo[1] ? i_data[31:16] : i_data[15:0];
  end

  always_comb begin
    o_data = i_data;
    o_err  = 1'b0;
    case (i_ext_op)
      EXT_NONE: o_data = i_data;
      EXT_LB:   o_data = {{24{w_byte[7]}}, w_byte};
      EXT_LBU:  o_data = {24'd0, w_byte};
      EXT_LH, EXT_LHU: begin
        if (i_addr_lo[0]) begin
          // Odd halfword address: no valid lane, force zero and flag
          o_data = 32'd0;
          o_err  = 1'b1;
        end else if (i_ext_op == EXT_LH) begin
          o_data = {{16{w_half[15]}}, w_half};
        end else begin
          o_data = {16'd0, w_half};
        end
      end
      // Undefined opcodes pass the word through unextended but flag it
      default:  o_err = 1'b1;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/wb_select_stage.sv
`default_nettype none
// ============================================================================
// Module      : wb_select_stage
// Description : Writeback result select. Picks one of NUM_SRC sources,
//               applies load extension to source EXT_SRC, and registers the
//               result toward the register file through a 2-entry skid
//               buffer (main output register + skid) with valid/ready.
// Ports       : clk, reset (sync, active-high), flush (sync discard)
//               in_valid/in_ready, in_src (flattened), in_sel, in_ext_op,
//               in_addr_lo, in_rd                         -- upstream entry
//               out_valid/out_ready, out_data, out_rd, out_we, sel_err
//                                                         -- downstream entry
// Note        : WIDTH must be 32 (extension lanes are bytes/halves of 32).
// Revision    : 1.0  initial release
// ============================================================================
module wb_select_stage
  import wb_select_stage_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int NUM_SRC = 4,
  parameter int SEL_W   = 2,
  parameter int EXT_SRC = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [NUM_SRC*WIDTH-1:0] in_src,
  input  logic [SEL_W-1:0]         in_sel,
  input  logic [2:0]               in_ext_op,
  input  logic [1:0]               in_addr_lo,
  input  logic [GPR_W-1:0]         in_rd,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_data,
  output logic [GPR_W-1:0]         out_rd,
  output logic                     out_we,
  output logic                     sel_err
);

  // Selection / extension (pre-register)
  logic [WIDTH-1:0] w_raw;
  logic             w_sel_ok;
  logic [WIDTH-1:0] w_ext_data;
  logic             w_ext_err;
  logic [WIDTH-1:0] w_data;
  logic             w_err;

  // Storage
  logic             r_main_valid;
  logic [WIDTH-1:0] r_main_data;
  logic [GPR_W-1:0] r_main_rd;
  logic             r_main_err;
  logic             r_skid_valid;
  logic [WIDTH-1:0] r_skid_data;
  logic [GPR_W-1:0] r_skid_rd;
  logic             r_skid_err;
  logic             r_in_ready;

  logic w_in_xfer;
  logic w_out_xfer;
  logic w_main_free;
  logic w_skid_valid_nxt;

  always_comb begin
    w_raw    = '0;
    w_sel_ok = 1'b0;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (in_sel == SEL_W'(k)) begin
        w_raw    = in_src[k*WIDTH +: WIDTH];
        w_sel_ok = 1'b1;
      end
    end
  end

  load_ext u_load_ext (
    .i_data    (w_raw),
    .i_ext_op  (in_ext_op),
    .i_addr_lo (in_addr_lo),
    .o_data    (w_ext_data),
    .o_err     (w_ext_err)
  );

  always_comb begin
    if (!w_sel_ok) begin
      w_data = '0;
      w_err  = 1'b1;
    end else if (in_sel == SEL_W'(EXT_SRC)) begin
      w_data = w_ext_data;
      w_err  = w_ext_err;
    end else begin
      w_data = w_raw;
      w_err  = 1'b0;
    end
  end

  assign w_in_xfer   = in_valid & r_in_ready;
  assign w_out_xfer  = r_main_valid & out_ready;
  // Main can be loaded this edge if it is empty or its entry is leaving
  assign w_main_free = !r_main_valid | w_out_xfer;
  // Skid occupancy after this edge; drives the registered in_ready
  assign w_skid_valid_nxt = w_main_free ? (r_skid_valid & w_in_xfer)
                                        : (r_skid_valid | w_in_xfer);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_main_valid <= 1'b0;
      r_main_data  <= '0;
      r_main_rd    <= '0;
      r_main_err   <= 1'b0;
      r_skid_valid <= 1'b0;
      r_skid_data  <= '0;
      r_skid_rd    <= '0;
      r_skid_err   <= 1'b0;
      r_in_ready   <= 1'b0;
    end else if (flush) begin
      r_main_valid <= 1'b0;
      r_skid_valid <= 1'b0;
      r_in_ready   <= 1'b1;
    end else begin
      if (w_main_free) begin
        if (r_skid_valid) begin
          // Oldest entry (skid) advances; any new input backfills skid
          r_main_valid <= 1'b1;
          r_main_data  <= r_skid_data;
          r_main_rd    <= r_skid_rd;
          r_main_err   <= r_skid_err;
          if (w_in_xfer) begin
            r_skid_data <= w_data;
            r_skid_rd   <= in_rd;
            r_skid_err  <= w_err;
          end
        end else begin
          r_main_valid <= w_in_xfer;
          if (w_in_xfer) begin
            r_main_data <= w_data;
            r_main_rd   <= in_rd;
            r_main_err  <= w_err;
          end
        end
      end else if (w_in_xfer) begin
        r_skid_data <= w_data;
        r_skid_rd   <= in_rd;
        r_skid_err  <= w_err;
      end
      r_skid_valid <= w_skid_valid_nxt;
      r_in_ready   <= !w_skid_valid_nxt;
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_main_valid;
  assign out_data  = r_main_data;
  assign out_rd    = r_main_rd;
  assign sel_err   = r_main_err;
  assign out_we    = r_main_valid & (r_main_rd != '0) & !r_main_err;

endmodule
`default_nettype wire

// File: tb/tb_wb_select_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_wb_select_stage
// Description : Directed self-checking bench for wb_select_stage. A second
//               instance built with NUM_SRC=3 shares the stimulus and
//               covers the out-of-range select.
// Revision    : 1.0  initial release
// ============================================================================
module tb_wb_select_stage;

  logic         clk = 1'b0;
  logic         reset, flush, in_valid, out_ready;
  logic [1:0]   in_sel, in_addr_lo;
  logic [2:0]   in_ext_op;
  logic [4:0]   in_rd;
  logic [31:0]  s0, s1, s2, s3;

  logic         in_ready, out_valid, out_we, sel_err;
  logic [31:0]  out_data;
  logic [4:0]   out_rd;

  logic         in_ready3, out_valid3, out_we3, sel_err3;
  logic [31:0]  out_data3;
  logic [4:0]   out_rd3;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  wb_select_stage #(.WIDTH(32), .NUM_SRC(4), .SEL_W(2), .EXT_SRC(1)) u_dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_src({s3, s2, s1, s0}), .in_sel(in_sel), .in_ext_op(in_ext_op),
    .in_addr_lo(in_addr_lo), .in_rd(in_rd),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_rd(out_rd), .out_we(out_we), .sel_err(sel_err)
  );

  wb_select_stage #(.WIDTH(32), .NUM_SRC(3), .SEL_W(2), .EXT_SRC(1)) u_dut3 (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready3),
    .in_src({s2, s1, s0}), .in_sel(in_sel), .in_ext_op(in_ext_op),
    .in_addr_lo(in_addr_lo), .in_rd(in_rd),
    .out_valid(out_valid3), .out_ready(out_ready), .out_data(out_data3),
    .out_rd(out_rd3), .out_we(out_we3), .sel_err(sel_err3)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one entry for a single cycle with out_ready=1, then check it
  task automatic send(input string tag, input logic [1:0] sel, input logic [2:0] op,
                      input logic [1:0] lo, input logic [4:0] rd,
                      input logic [31:0] exp_d, input logic exp_err, input logic exp_we);
    in_valid = 1'b1; in_sel = sel; in_ext_op = op; in_addr_lo = lo; in_rd = rd;
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    chk({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
    chk({tag, "_data"},  out_data, exp_d);
    chk({tag, "_err"},   {31'd0, sel_err}, {31'd0, exp_err});
    chk({tag, "_we"},    {31'd0, out_we},  {31'd0, exp_we});
  endtask

  task automatic push(input logic [31:0] d, input logic [4:0] rd);
    in_valid = 1'b1; in_sel = 2'd0; in_ext_op = 3'd0; in_addr_lo = 2'd0;
    in_rd = rd; s0 = d;
    step();
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_sel = 2'd0; in_ext_op = 3'd0; in_addr_lo = 2'd0; in_rd = 5'd0;
    s0 = 32'h1234_5678; s1 = 32'h0000_80F0; s2 = 32'hDEAD_BEEF; s3 = 32'h0BAD_F00D;
    step(); step();
    // Reset state
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_data",  out_data, 32'd0);
    chk("rst_rd",    {27'd0, out_rd}, 32'd0);
    chk("rst_we",    {31'd0, out_we}, 32'd0);
    chk("rst_err",   {31'd0, sel_err}, 32'd0);
    chk("rst_ready", {31'd0, in_ready}, 32'd0);
    reset = 1'b0;
    step();
    chk("post_rst_ready", {31'd0, in_ready}, 32'd1);

    // Plain select and load extension
    send("src0",    2'd0, 3'd0, 2'd0, 5'd8, 32'h1234_5678, 1'b0, 1'b1);
    send("lb0",     2'd1, 3'd1, 2'd0, 5'd9, 32'hFFFF_FFF0, 1'b0, 1'b1);
    send("lbu1",    2'd1, 3'd2, 2'd1, 5'd9, 32'h0000_0080, 1'b0, 1'b1);
    send("lh0",     2'd1, 3'd3, 2'd0, 5'd9, 32'hFFFF_80F0, 1'b0, 1'b1);
    send("lh_mis",  2'd1, 3'd3, 2'd1, 5'd9, 32'h0000_0000, 1'b1, 1'b0);
    send("lhu2",    2'd1, 3'd4, 2'd2, 5'd9, 32'h0000_0000, 1'b0, 1'b1);
    send("op5",     2'd1, 3'd5, 2'd0, 5'd9, 32'h0000_80F0, 1'b1, 1'b0);
    send("noext0",  2'd0, 3'd1, 2'd0, 5'd3, 32'h1234_5678, 1'b0, 1'b1);
    send("src3",    2'd3, 3'd0, 2'd0, 5'd4, 32'h0BAD_F00D, 1'b0, 1'b1);
    // Same cycle on the 3-source build: select 3 is out of range
    chk("n3_valid", {31'd0, out_valid3}, 32'd1);
    chk("n3_data",  out_data3, 32'd0);
    chk("n3_err",   {31'd0, sel_err3}, 32'd1);
    chk("n3_we",    {31'd0, out_we3}, 32'd0);
    send("rd0",     2'd2, 3'd0, 2'd0, 5'd0, 32'hDEAD_BEEF, 1'b0, 1'b0);

    // Drain, then backpressure with A, B, C
    out_ready = 1'b1; step();
    chk("drain_valid", {31'd0, out_valid}, 32'd0);
    chk("hold_data",   out_data, 32'hDEAD_BEEF);
    out_ready = 1'b0;
    push(32'hAAAA_0001, 5'd1);
    chk("bp_A_ready", {31'd0, in_ready}, 32'd1);
    push(32'hBBBB_0002, 5'd2);
    chk("bp_full_ready", {31'd0, in_ready}, 32'd0);
    push(32'hCCCC_0003, 5'd3);   // C waits, not accepted
    chk("bp_hold_data", out_data, 32'hAAAA_0001);
    chk("bp_hold_ready", {31'd0, in_ready}, 32'd0);
    out_ready = 1'b1;            // A leaves on the next edge
    step();
    chk("ord_B", out_data, 32'hBBBB_0002);
    chk("ord_B_rd", {27'd0, out_rd}, 32'd2);
    chk("ord_B_ready", {31'd0, in_ready}, 32'd1);
    step();                      // B leaves, C accepted
    in_valid = 1'b0;
    chk("ord_C", out_data, 32'hCCCC_0003);
    chk("ord_C_valid", {31'd0, out_valid}, 32'd1);
    step();
    chk("ord_end_valid", {31'd0, out_valid}, 32'd0);

    // Flush with both entries full
    out_ready = 1'b0;
    push(32'h1111_0001, 5'd5);
    push(32'h2222_0002, 5'd6);
    flush = 1'b1; in_valid = 1'b1; s0 = 32'h3333_0003;
    step();
    flush = 1'b0; in_valid = 1'b0;
    chk("fl_valid", {31'd0, out_valid}, 32'd0);
    chk("fl_ready", {31'd0, in_ready}, 32'd1);
    // Flush with main only: the accepted-looking input must be dropped
    push(32'h4444_0004, 5'd7);
    flush = 1'b1; in_valid = 1'b1; s0 = 32'h5555_0005;
    step();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    chk("fl2_valid", {31'd0, out_valid}, 32'd0);
    step();
    chk("fl2_after_valid", {31'd0, out_valid}, 32'd0);

    // Reset mid-stream
    out_ready = 1'b0;
    push(32'h6666_0006, 5'd8);
    push(32'h7777_0007, 5'd9);
    in_valid = 1'b0; reset = 1'b1;
    step();
    chk("mrst_valid", {31'd0, out_valid}, 32'd0);
    chk("mrst_data",  out_data, 32'd0);
    chk("mrst_rd",    {27'd0, out_rd}, 32'd0);
    chk("mrst_we",    {31'd0, out_we}, 32'd0);
    chk("mrst_ready", {31'd0, in_ready}, 32'd0);
    reset = 1'b0;
    step();
    chk("mrst_ready_after", {31'd0, in_ready}, 32'd1);
    chk("mrst_valid_after", {31'd0, out_valid}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
